// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory controller: FSM state encoding and default widths.
package dmem_pkg;

  localparam int ADDR_W_DEF     = 24;
  localparam int DATA_W_DEF     = 24;
  localparam int MEM_W_DEF      = 16;
  localparam int DEPTH_LOG2_DEF = 18;

  typedef enum logic {
    IDLE = 1'b0,
    RSP  = 1'b1
  } state_t;

endpackage

// File: rtl/dmem_bank.sv
// Single-port synchronous RAM; q is a registered read port that only updates on re.
module dmem_bank #(
  parameter int MEM_W      = 16,
  parameter int DEPTH_LOG2 = 18
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic                  re,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [MEM_W-1:0]      wdata,
  output logic [MEM_W-1:0]      q
);

  logic [MEM_W-1:0] r_mem [1 << DEPTH_LOG2];

  // NOTE: storage and q carry no reset, so the array maps onto a RAM macro and contents survive rst.
  always_ff @(posedge clk) begin
    if (we) r_mem[addr] <= wdata;
    if (re) q <= r_mem[addr];
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: valid/ready request port, 1-cycle read response, no write response.
// Optional bounds checking of upper address bits is enabled with `define DMEM_BOUNDS_CHECK_EN.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int MEM_W      = MEM_W_DEF,
  parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF,
  parameter int EXT_SIGNED = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_err;
  logic             w_accept;
  logic             w_rd;
  logic             w_oor;
  logic [MEM_W-1:0] w_q;
  logic [DATA_W-1:0] w_ext;
  logic             w_unused;

  // Only the low address bits and low data bits reach the RAM.
  assign w_unused = ^{req_addr, req_wdata};

`ifdef DMEM_BOUNDS_CHECK_EN
  if (DEPTH_LOG2 < ADDR_W) begin : g_oor
    assign w_oor = |req_addr[ADDR_W-1:DEPTH_LOG2];
  end else begin : g_no_oor
    assign w_oor = 1'b0;
  end
`else
  assign w_oor = 1'b0;
`endif

  assign req_ready = !rst && (r_state == IDLE || rsp_ready);
  assign w_accept  = req_valid && req_ready;
  assign w_rd      = w_accept && !req_we;

  dmem_bank #(
    .MEM_W      (MEM_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_bank (
    .clk   (clk),
    .we    (w_accept && req_we && !w_oor),
    .re    (w_rd && !w_oor),
    .addr  (req_addr[DEPTH_LOG2-1:0]),
    .wdata (req_wdata[MEM_W-1:0]),
    .q     (w_q)
  );

  always_comb begin
    // NOTE: next-state gets a default before the case so no path leaves it unassigned (no latch).
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_rd) w_state_nxt = RSP;
      RSP:     if (!w_rd && rsp_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_rd) r_err <= w_oor;
    end
  end

  if (MEM_W < DATA_W) begin : g_ext
    assign w_ext = {{(DATA_W-MEM_W){(EXT_SIGNED != 0) ? w_q[MEM_W-1] : 1'b0}}, w_q};
  end else begin : g_noext
    assign w_ext = w_q;
  end

  // Outputs are gated with rst so they read as idle for the whole reset cycle.
  assign rsp_valid = (r_state == RSP) && !rst;
  assign rsp_err   = rsp_valid && r_err;
  assign rsp_rdata = (rsp_valid && !r_err) ? w_ext : '0;

endmodule
